// File: rtl/crypto_wallet_seed_port.sv
// Avalon-MM seed port: NUM_WORDS staging words committed atomically to a shadow
// bus, handed to the seed consumer over a valid/ack handshake, with status and irq.
//
// state      | meaning
// ST_IDLE    | no committed seed outstanding; a COMMIT loads the shadow
// ST_PENDING | shadow held on out_port with seed_valid=1 until seed_ack
module crypto_wallet_seed_port #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_WORDS   = 8,
  parameter int                    ADDR_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [ADDR_WIDTH-1:0]           address,
  input  logic                            chipselect,
  input  logic                            write_n,
  input  logic [DATA_WIDTH/8-1:0]         byteenable,
  input  logic [DATA_WIDTH-1:0]           writedata,
  output logic [DATA_WIDTH-1:0]           readdata,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] out_port,
  output logic                            seed_valid,
  input  logic                            seed_ack,
  output logic                            irq
);

  localparam int                    BE_W   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(NUM_WORDS + 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t                          r_state;
  logic [DATA_WIDTH-1:0]           r_staging [NUM_WORDS];
  logic [NUM_WORDS*DATA_WIDTH-1:0] r_shadow;
  logic                            r_seed_valid;
  logic                            r_done;
  logic                            r_overrun;
  logic                            r_irq_en;
  logic                            r_irq;

  logic                            w_wr;
  logic                            w_ctrl_wr;
  logic                            w_stat_wr;
  logic                            w_commit;
  logic                            w_clear;
  logic                            w_w1c_done;
  logic                            w_w1c_ovr;
  logic [NUM_WORDS*DATA_WIDTH-1:0] w_staging_flat;
  logic [DATA_WIDTH-1:0]           w_rdata;

  assign w_wr       = chipselect & ~write_n;
  assign w_ctrl_wr  = w_wr & (address == A_CTRL) & byteenable[0];
  assign w_stat_wr  = w_wr & (address == A_STAT) & byteenable[0];
  assign w_commit   = w_ctrl_wr & writedata[0];
  assign w_clear    = w_ctrl_wr & writedata[1];
  assign w_w1c_done = w_stat_wr & writedata[1];
  assign w_w1c_ovr  = w_stat_wr & writedata[2];

  always_comb begin
    w_staging_flat = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      w_staging_flat[i*DATA_WIDTH +: DATA_WIDTH] = r_staging[i];
    end
  end

  // CLEAR and a staging write can never coincide: they decode different addresses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_staging[i] <= RESET_VALUE;
      end
    end else if (w_clear) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_staging[i] <= '0;
      end
    end else if (w_wr) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (address == ADDR_WIDTH'(i)) begin
          for (int b = 0; b < BE_W; b++) begin
            if (byteenable[b]) begin
              r_staging[i][b*8 +: 8] <= writedata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Sticky clears are written first so a same-cycle set event overrides them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_seed_valid <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_shadow     <= {NUM_WORDS{RESET_VALUE}};
    end else begin
      if (w_w1c_done) r_done <= 1'b0;
      if (w_w1c_ovr) r_overrun <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_commit) begin
          r_shadow     <= w_staging_flat;
          r_state      <= ST_PENDING;
          r_seed_valid <= 1'b1;
        end
      end else begin
        if (w_commit) r_overrun <= 1'b1;
        if (seed_ack) begin
          r_state      <= ST_IDLE;
          r_seed_valid <= 1'b0;
          r_done       <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= writedata[2];
      r_irq <= r_irq_en & (r_done | r_overrun);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (address == A_CTRL) begin
      w_rdata[2] = r_irq_en;
    end else if (address == A_STAT) begin
      w_rdata[0] = r_seed_valid;
      w_rdata[1] = r_done;
      w_rdata[2] = r_overrun;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (address == ADDR_WIDTH'(i)) w_rdata = r_staging[i];
      end
    end
  end

  assign readdata   = w_rdata;
  assign out_port   = r_shadow;
  assign seed_valid = r_seed_valid;
  assign irq        = r_irq;

endmodule

// File: tb/tb_crypto_wallet_seed_port.sv
// Bench for crypto_wallet_seed_port: directed walk through the main scenarios, then
// randomized bus/ack traffic checked every cycle against a register-level model.
module tb_crypto_wallet_seed_port;

  localparam int DW = 32;
  localparam int NW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [3:0]    byteenable = '0;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] readdata;
  logic [NW*DW-1:0] out_port;
  logic          seed_valid;
  logic          seed_ack = 1'b0;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] m_stg [NW];
  logic [31:0] m_sh  [NW];
  logic        m_pend, m_done, m_ovr, m_irq_en, m_irq;

  crypto_wallet_seed_port #(
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW),
    .ADDR_WIDTH (AW),
    .RESET_VALUE('0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .byteenable(byteenable),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .seed_valid(seed_valid),
    .seed_ack  (seed_ack),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_stg[i] = '0;
      m_sh[i]  = '0;
    end
    m_pend = 0; m_done = 0; m_ovr = 0; m_irq_en = 0; m_irq = 0;
  endtask

  function automatic logic [255:0] exp_out();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < NW; i++) v[i*32 +: 32] = m_sh[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    if (a < NW) return m_stg[a];
    if (a == NW) return {29'b0, m_irq_en, 2'b00};
    if (a == NW + 1) return {29'b0, m_ovr, m_done, m_pend};
    return 32'h0;
  endfunction

  // One clock edge of the register map, applied to the model.
  task automatic model_step(input logic cs, input logic wn, input int a,
                            input logic [3:0] be, input logic [31:0] wd, input logic ack);
    logic wr, commit, clear, set_done, set_ovr, clr_done, clr_ovr;
    logic [31:0] pre [NW];
    wr = cs && !wn;
    commit = 0; clear = 0; set_done = 0; set_ovr = 0; clr_done = 0; clr_ovr = 0;
    m_irq = m_irq_en && (m_done || m_ovr);
    for (int i = 0; i < NW; i++) pre[i] = m_stg[i];
    if (wr && a < NW) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_stg[a][b*8 +: 8] = wd[b*8 +: 8];
    end
    if (wr && a == NW && be[0]) begin
      commit = wd[0];
      clear = wd[1];
      m_irq_en = wd[2];
    end
    if (wr && a == NW + 1 && be[0]) begin
      clr_done = wd[1];
      clr_ovr = wd[2];
    end
    if (m_pend) begin
      if (commit) set_ovr = 1;
      if (ack) begin
        m_pend = 0;
        set_done = 1;
      end
    end else if (commit) begin
      for (int i = 0; i < NW; i++) m_sh[i] = pre[i];
      m_pend = 1;
    end
    m_done = set_done || (m_done && !clr_done);
    m_ovr  = set_ovr || (m_ovr && !clr_ovr);
    if (clear) for (int i = 0; i < NW; i++) m_stg[i] = '0;
  endtask

  task automatic cyc(input logic cs, input logic wn, input int a,
                     input logic [3:0] be, input logic [31:0] wd, input logic ack);
    chipselect = cs; write_n = wn; address = AW'(a);
    byteenable = be; writedata = wd; seed_ack = ack;
    @(posedge clk);
    model_step(cs, wn, a, be, wd, ack);
    #1;
    chk("seed_valid", {255'b0, seed_valid}, {255'b0, m_pend});
    chk("irq", {255'b0, irq}, {255'b0, m_irq});
    chk("out_port", out_port, exp_out());
    chk("readdata", {224'b0, readdata}, {224'b0, exp_rd(a)});
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    cyc(1, 0, a, be, d, 0);
  endtask

  task automatic rd(input int a);
    cyc(0, 1, a, 4'h0, 32'h0, 0);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_seed_valid", {255'b0, seed_valid}, 256'h0);
    chk("rst_out_port", out_port, 256'h0);
    chk("rst_irq", {255'b0, irq}, 256'h0);
    address = AW'(NW + 1);
    #1;
    chk("rst_status", {224'b0, readdata}, 256'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // staging write and readback
    wr(0, 32'hDEADBEEF, 4'hF);
    wr(7, 32'h12345678, 4'hF);
    rd(0);
    chk("word0", {224'b0, readdata}, {224'b0, 32'hDEADBEEF});
    rd(7);
    chk("word7", {224'b0, readdata}, {224'b0, 32'h12345678});
    chk("out_before_commit", out_port, 256'h0);

    // commit and hold
    wr(NW, 32'h1, 4'hF);
    chk("commit_w0", {224'b0, out_port[31:0]}, {224'b0, 32'hDEADBEEF});
    chk("commit_w7", {224'b0, out_port[255:224]}, {224'b0, 32'h12345678});
    chk("commit_valid", {255'b0, seed_valid}, {255'b0, 1'b1});
    rd(NW + 1);
    chk("status_pending", {224'b0, readdata}, {224'b0, 32'h1});
    for (int i = 0; i < 10; i++) rd(NW + 1);
    chk("hold_valid", {255'b0, seed_valid}, {255'b0, 1'b1});

    // ack, done, irq, W1C
    cyc(0, 1, NW + 1, 4'h0, 32'h0, 1);
    chk("ack_valid", {255'b0, seed_valid}, 256'h0);
    chk("status_done", {224'b0, readdata}, {224'b0, 32'h2});
    wr(NW, 32'h4, 4'hF);
    rd(NW + 1);
    chk("irq_done", {255'b0, irq}, {255'b0, 1'b1});
    wr(NW + 1, 32'h2, 4'hF);
    chk("status_w1c", {224'b0, readdata}, 256'h0);
    rd(NW + 1);
    chk("irq_cleared", {255'b0, irq}, 256'h0);

    // overrun while pending
    wr(NW, 32'h5, 4'hF);
    wr(0, 32'h1, 4'hF);
    wr(NW, 32'h5, 4'hF);
    chk("ovr_out_stable", {224'b0, out_port[31:0]}, {224'b0, 32'hDEADBEEF});
    rd(NW + 1);
    chk("status_overrun", {224'b0, readdata}, {224'b0, 32'h5});
    cyc(0, 1, 0, 4'h0, 32'h0, 1);
    wr(NW, 32'h5, 4'hF);
    chk("recommit_w0", {224'b0, out_port[31:0]}, {224'b0, 32'h1});
    cyc(0, 1, 0, 4'h0, 32'h0, 1);
    wr(NW + 1, 32'h6, 4'hF);

    // byte lanes, commit+clear, CTRL with byteenable[0]=0
    wr(1, 32'hAABBCCDD, 4'b0101);
    rd(1);
    chk("byte_lanes", {224'b0, readdata}, {224'b0, 32'h00BB00DD});
    wr(NW, 32'h3, 4'hF);
    chk("clr_shadow_w1", {224'b0, out_port[63:32]}, {224'b0, 32'h00BB00DD});
    for (int i = 0; i < NW; i++) begin
      rd(i);
      chk("cleared_word", {224'b0, readdata}, 256'h0);
    end
    wr(NW, 32'h3, 4'h0);
    rd(NW + 1);
    chk("be0_ignored", {224'b0, readdata}, {224'b0, 32'h1});

    // asynchronous reset between edges while pending
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {255'b0, seed_valid}, 256'h0);
    chk("arst_out", out_port, 256'h0);
    chk("arst_status", {224'b0, readdata}, 256'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [3:0] be;
      r = $urandom_range(0, 19);
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      cyc($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), (r < 16) ? r : NW,
          be, $urandom, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
